bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the 8-bit, 6-source select bus (sources a..f, select lines S2..S0) between six requesters.
- Grants one owner at a time and drives the bus select lines. Caps ownership at MAX_HOLD cycles while others wait.
- Inserts one dead turnaround cycle between owners so the bus output is never considered valid during a select change.
- Sits beside the bus mux; its S0/S1/S2 outputs wire directly to the mux select inputs.

Parameters:
- NUM_SRC, 6, number of requesters; fixed to the bus source count, not to be overridden.
- SEL_W, 3, select width.
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester is waiting; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- req  input  6  request per source; bit i corresponds to bus source i (a=0 .. f=5). Requester holds it high for as long as it wants the bus.
- gnt  output  6  one-hot grant, registered; all-zero when no owner.
- S0  output  1  bus select bit 0, registered.
- S1  output  1  bus select bit 1, registered.
- S2  output  1  bus select bit 2, registered.
- bus_valid  output  1  high exactly when gnt is non-zero; bus output is meaningful.

Behaviour:
- Reset values on the rst_n low edge: gnt=0, {S2,S1,S0}=000, bus_valid=0, state=IDLE, last_ptr=5 (so source 0 has first priority), hold_cnt=0.
- States: IDLE, GRANT, TURN; registered two-bit encoding.
- Winner: the first set req bit searching circularly from last_ptr+1 (mod 6). The search is combinational on the current req.
- IDLE:
  - If any req: next edge enters GRANT with gnt[w]=1, sel=w, bus_valid=1, last_ptr=w, hold_cnt=1. Latency is req to gnt in 1 cycle.
  - Else remain in IDLE; outputs hold.
- GRANT (owner o = last_ptr):
  - If req[o]=0: next edge enters TURN.
  - Else if hold_cnt==MAX_HOLD and any req[j], j!=o: next edge enters TURN (preemption).
  - Else stay in GRANT; hold_cnt increments, saturating at MAX_HOLD. A sole requester keeps the bus indefinitely.
- TURN:
  - Exactly one cycle with gnt=0 and bus_valid=0; {S2,S1,S0} retains the previous owner's value.
  - Next edge: if any req, enter GRANT to the new winner (searched from o+1). Otherwise enter IDLE.
  - A preempted owner still requesting competes at lowest priority.
- Select changes only on the edge that asserts a new grant. gnt, sel and bus_valid always update on the same edge.
- Simultaneous events:
  - Owner drop and a new request arriving in the same cycle: TURN first, then arbitrate with the req values sampled in TURN.
  - Requests asserting during TURN are included in that cycle's arbitration.
- Reset mid-operation: on any edge with rst_n=0, all reset values apply, regardless of state or req.
- Invariants: gnt is zero or one-hot; bus_valid == |gnt; when bus_valid=1, sel == index of the gnt bit; sel is never 6 or 7.

Decomposition:
- Shared include bus_defs.vh holds:
  - NUM_SRC=6 and SEL_W=3.
  - Source index constants SRC_A..SRC_F = 0..5.
  - State encodings ST_IDLE=0, ST_GRANT=1, ST_TURN=2.
- Sub-module rr_pick: combinational 6-way circular priority picker.
  - Inputs: req[5:0], last_ptr[2:0].
  - Outputs: any, win[2:0].
  - Reused by future bus clients.
- The top level holds the FSM, hold_cnt, last_ptr and output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=111111, then release -> during reset gnt=000000, sel=000, bus_valid=0. First edge after release gives gnt=000001, sel=000.
- Single requester: req=000100 from cycle 0, dropped at cycle 5 -> cycles 1-5 gnt=000100, sel=010, bus_valid=1. Cycle 6 gnt=0, sel=010 (TURN). Cycle 7 onward IDLE, gnt=0.
- Full contention: req=111111 held, MAX_HOLD=4 -> each owner granted for 4 cycles, then 1 dead cycle. Owners in order 0,1,2,3,4,5,0; sel 000,001,010,011,100,101,000; cycle period 30.
- Sole holder: req=100000 for 20 cycles -> gnt=100000 continuously from cycle 1, no TURN inserted, hold_cnt saturated at 4.
- Simultaneous: owner 2 drops req in the same cycle req[1] and req[3] rise -> one TURN cycle, then gnt=001000, sel=011. Source 1 is granted only after source 3 releases.
- Reset mid-grant: rst_n=0 for one cycle while gnt=010000 -> next edge gives gnt=0, sel=000, IDLE. After release with req=010000 held, gnt=010000 one cycle later.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and index helper for the six-source bus arbiter.
package bus_arbiter_pkg;

  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;
  localparam int HOLD_W  = 4;

  localparam logic [SEL_W-1:0] SRC_A = 3'd0;
  localparam logic [SEL_W-1:0] SRC_B = 3'd1;
  localparam logic [SEL_W-1:0] SRC_C = 3'd2;
  localparam logic [SEL_W-1:0] SRC_D = 3'd3;
  localparam logic [SEL_W-1:0] SRC_E = 3'd4;
  localparam logic [SEL_W-1:0] SRC_F = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Folds an index in 0..11 back into 0..NUM_SRC-1.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W:0] v);
    logic [SEL_W:0] r;
    r = (v >= 4'(NUM_SRC)) ? v - 4'(NUM_SRC) : v;
    return r[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant/select bundle between the requesters and the bus arbiter.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic               S0;
  logic               S1;
  logic               S2;
  logic               bus_valid;

  modport master (output req, input gnt, input S0, input S1, input S2, input bus_valid);
  modport slave  (input req, output gnt, output S0, output S1, output S2, output bus_valid);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational circular priority picker: first set req bit after last_ptr, wrapping at NUM_SRC.
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last_ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] cand [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand[gi] = wrap_idx({1'b0, last_ptr} + 4'(gi + 1));
    end
  endgenerate

  // Scan from lowest priority to highest so the nearest requester overwrites.
  always_comb begin
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[cand[k]]) win = cand[k];
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner FSM for the six-source select bus, with hold cap and one dead turnaround cycle.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] gnt_reg, gnt_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               valid_reg, valid_next;
  logic [SEL_W-1:0]   last_ptr_reg, last_ptr_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;

  logic               any;
  logic [SEL_W-1:0]   win;
  logic               owner_req;
  logic               others_req;

  bus_arbiter_rr_pick u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr_reg),
    .any      (any),
    .win      (win)
  );

  // In GRANT the one-hot gnt register identifies the owner directly.
  assign owner_req  = |(bus.req & gnt_reg);
  assign others_req = |(bus.req & ~gnt_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      valid_reg    <= 1'b0;
      last_ptr_reg <= SRC_F;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      valid_reg    <= valid_next;
      last_ptr_reg <= last_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    valid_next    = valid_reg;
    last_ptr_next = last_ptr_reg;
    hold_cnt_next = hold_cnt_reg;

    unique case (state_reg)
      ST_IDLE, ST_TURN: begin
        if (any) begin
          state_next    = ST_GRANT;
          gnt_next      = NUM_SRC'(1) << win;
          sel_next      = win;
          valid_next    = 1'b1;
          last_ptr_next = win;
          hold_cnt_next = HOLD_W'(1);
        end else begin
          state_next = ST_IDLE;
          gnt_next   = '0;
          valid_next = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (hold_cnt_reg == HOLD_MAX && others_req)) begin
          // Select is left alone so the mux does not switch during the dead cycle.
          state_next = ST_TURN;
          gnt_next   = '0;
          valid_next = 1'b0;
        end else if (hold_cnt_reg != HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = gnt_reg;
  assign bus.S0        = sel_reg[0];
  assign bus.S1        = sel_reg[1];
  assign bus.S2        = sel_reg[2];
  assign bus.bus_valid = valid_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector table plus a hand-written preemption sequence for bus_arbiter.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  typedef struct {
    logic       rst_n;
    logic [5:0] req;
    logic [5:0] gnt;
    logic [2:0] sel;
    logic       valid;
  } vec_t;

  logic clk;
  logic rst_n;
  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  bus_arbiter_if bus ();

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] q, input logic [5:0] g,
                     input logic [2:0] s, input logic v);
    vec_t e;
    e.rst_n = r; e.req = q; e.gnt = g; e.sel = s; e.valid = v;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [2:0] cur_sel();
    return {bus.S2, bus.S1, bus.S0};
  endfunction

  // Invariants that must hold after every edge.
  task automatic check_inv(input string tag);
    logic ok;
    ok = (bus.bus_valid == |bus.gnt) && ($countones(bus.gnt) <= 1) && (cur_sel() < 3'd6) &&
         (!bus.bus_valid || bus.gnt == (6'd1 << cur_sel()));
    check({tag, "_inv"}, {15'd0, ok}, 16'd1);
  endtask

  initial begin
    int cnt;
    logic [2:0] prev;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.req = '0;

    // Reset with everyone requesting, then full contention round.
    add(0, 6'h3F, 6'h00, 3'd0, 0);
    add(0, 6'h3F, 6'h00, 3'd0, 0);
    for (int i = 0; i < 4; i++) add(1, 6'h3F, 6'h01, 3'd0, 1);
    prev = 3'd0;
    for (int o = 1; o <= 6; o++) begin
      logic [2:0] idx;
      idx = 3'(o % 6);
      add(1, 6'h3F, 6'h00, prev, 0);
      for (int i = 0; i < 4; i++) add(1, 6'h3F, 6'd1 << idx, idx, 1);
      prev = idx;
    end
    // Single requester on source c.
    add(0, 6'h04, 6'h00, 3'd0, 0);
    for (int i = 0; i < 5; i++) add(1, 6'h04, 6'h04, 3'd2, 1);
    add(1, 6'h00, 6'h00, 3'd2, 0);
    add(1, 6'h00, 6'h00, 3'd2, 0);
    add(1, 6'h00, 6'h00, 3'd2, 0);
    // Sole holder on source f never gets a turnaround.
    for (int i = 0; i < 20; i++) add(1, 6'h20, 6'h20, 3'd5, 1);
    add(1, 6'h00, 6'h00, 3'd5, 0);
    add(1, 6'h00, 6'h00, 3'd5, 0);
    // Owner drop coinciding with new requests on b and d.
    add(0, 6'h04, 6'h00, 3'd0, 0);
    for (int i = 0; i < 3; i++) add(1, 6'h04, 6'h04, 3'd2, 1);
    add(1, 6'h0A, 6'h00, 3'd2, 0);
    add(1, 6'h0A, 6'h08, 3'd3, 1);
    add(1, 6'h0A, 6'h08, 3'd3, 1);
    add(1, 6'h02, 6'h00, 3'd3, 0);
    add(1, 6'h02, 6'h02, 3'd1, 1);
    // Hand over to e, then reset mid-grant.
    add(1, 6'h10, 6'h00, 3'd1, 0);
    add(1, 6'h10, 6'h10, 3'd4, 1);
    add(0, 6'h10, 6'h00, 3'd0, 0);
    add(1, 6'h10, 6'h10, 3'd4, 1);

    foreach (vecs[i]) begin
      string nm;
      rst_n   = vecs[i].rst_n;
      bus.req = vecs[i].req;
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d", i);
      $display("vec %0d rst_n=%b req=%b -> gnt=%b sel=%0d valid=%b", i, vecs[i].rst_n,
               vecs[i].req, bus.gnt, cur_sel(), bus.bus_valid);
      check(nm, {6'd0, bus.gnt, cur_sel(), bus.bus_valid},
            {6'd0, vecs[i].gnt, vecs[i].sel, vecs[i].valid});
      check_inv(nm);
    end

    // Two-way contention: owner a is capped at four cycles, then b after one dead cycle.
    rst_n   = 1'b0;
    bus.req = 6'h03;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("pair start gnt=%b sel=%0d", bus.gnt, cur_sel());
    check("pair_first", {10'd0, bus.gnt}, 16'h0001);
    cnt = 0;
    while (bus.gnt == 6'h01 && cnt < 20) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    $display("pair hold=%0d gnt=%b", cnt, bus.gnt);
    check("pair_hold", 16'(cnt), 16'd4);
    check("pair_turn", {7'd0, bus.gnt, cur_sel()}, {7'd0, 6'h00, 3'd0});
    @(posedge clk);
    #1;
    $display("pair next gnt=%b sel=%0d", bus.gnt, cur_sel());
    check("pair_next", {7'd0, bus.gnt, cur_sel()}, {7'd0, 6'h02, 3'd1});
    check_inv("pair");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
